// File: rtl/cam_pkg.sv
// cam_pkg: shared types and default dimensions for the CAM key-storage stage.
// Consumers import this package with import cam_pkg::*.
package cam_pkg;

    // Default dimensions for the key store
    localparam int CAM_ADDR_WIDTH = 8;
    localparam int CAM_KEY_WIDTH  = 16;

    // Sweep controller states: normal operation, or clearing valid bits one per cycle
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage : cam_pkg

// File: rtl/cam_entry.sv
// cam_entry: one CAM slot -- key register, optional don't-care mask register,
// valid flop and the comparator producing this slot's raw match bit.
// Optional ternary mask storage is built when CAM_STORE_MASK_EN is defined.
module cam_entry
    import cam_pkg::*;
#(
    parameter int KEY_WIDTH = CAM_KEY_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr,        // store i_key (and mask), set valid
    input  logic                 i_clr,       // clear valid; wins over i_wr
    input  logic [KEY_WIDTH-1:0] i_key,
`ifdef CAM_STORE_MASK_EN
    input  logic [KEY_WIDTH-1:0] i_mask,      // 1 = bit ignored in compare
`endif
    input  logic [KEY_WIDTH-1:0] i_srch_key,
    output logic                 o_match
);

    logic                 r_valid;
    logic [KEY_WIDTH-1:0] r_key;
    logic [KEY_WIDTH-1:0] w_diff;

    // Valid flop: a clear request beats a write so invalidate/flush win on a collision
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
        end
    end

    // Key storage: loaded on write, even when the same-cycle clear keeps the slot invalid
    always_ff @(posedge clk) begin
        // NOTE: key/mask storage has no reset; the valid bit alone decides whether the contents count.
        if (i_wr) begin
            r_key <= i_key;
        end
    end

`ifdef CAM_STORE_MASK_EN
    logic [KEY_WIDTH-1:0] r_mask;

    // Mask storage: captured alongside the key
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_mask <= i_mask;
        end
    end

    assign w_diff = (r_key ^ i_srch_key) & ~r_mask;
`else
    assign w_diff = r_key ^ i_srch_key;
`endif

    assign o_match = r_valid & ~(|w_diff);

endmodule : cam_entry

// File: rtl/cam_store.sv
// cam_store: DEPTH-entry key store with parallel compare and a registered
// multi-hot match vector for the downstream priority encoder. Supports write,
// invalidate and a one-entry-per-cycle flush sweep.
// Build option: define CAM_STORE_MASK_EN for per-entry ternary masks (adds wr_mask).
module cam_store
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int KEY_WIDTH  = CAM_KEY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0]  wr_key,
`ifdef CAM_STORE_MASK_EN
    input  logic [KEY_WIDTH-1:0]  wr_mask,
`endif
    input  logic                  inv_en,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  flush,
    output logic                  busy,
    input  logic                  srch_en,
    input  logic [KEY_WIDTH-1:0]  srch_key,
    output logic                  match_valid,
    output logic [DEPTH-1:0]      match_vec
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_flush_cnt;
    logic [ADDR_WIDTH-1:0] w_flush_cnt_nxt;
    logic                  r_match_valid;
    logic [DEPTH-1:0]      r_match_vec;
    logic [DEPTH-1:0]      w_raw_match;
    logic                  w_idle;

    assign w_idle = (r_state == IDLE);
    assign busy   = (r_state == FLUSH);

    // Entry array: per-slot write/clear decode, compare happens inside each slot
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic w_wr;
        logic w_clr;

        assign w_wr  = w_idle & wr_en & (wr_addr == ADDR_WIDTH'(g));
        assign w_clr = (w_idle & inv_en & (inv_addr == ADDR_WIDTH'(g)))
                     | (!w_idle & (r_flush_cnt == ADDR_WIDTH'(g)));

        cam_entry #(
            .KEY_WIDTH (KEY_WIDTH)
        ) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr       (w_wr),
            .i_clr      (w_clr),
            .i_key      (wr_key),
`ifdef CAM_STORE_MASK_EN
            .i_mask     (wr_mask),
`endif
            .i_srch_key (srch_key),
            .o_match    (w_raw_match[g])
        );
    end

    // State and sweep-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next-state logic: flush starts a DEPTH-cycle sweep, one valid bit per cycle
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = '0;
                end
            end
            FLUSH: begin
                w_flush_cnt_nxt = r_flush_cnt + ADDR_WIDTH'(1);
                if (r_flush_cnt == LAST_IDX) begin
                    w_state_nxt     = IDLE;
                    w_flush_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    // Result registers: capture compare in IDLE, hold vector during the sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match_valid <= 1'b0;
            r_match_vec   <= '0;
        end else if (w_idle) begin
            r_match_valid <= srch_en;
            r_match_vec   <= srch_en ? w_raw_match : '0;
        end else begin
            r_match_valid <= 1'b0;
        end
    end

    assign match_valid = r_match_valid;
    assign match_vec   = r_match_vec;

endmodule : cam_store

// File: tb/tb_cam_store.sv
// tb_cam_store: directed self-checking bench for cam_store.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
// Define CAM_STORE_MASK_EN to exercise the ternary-mask build.
module tb_cam_store;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int KW    = 16;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [KW-1:0]    wr_key;
`ifdef CAM_STORE_MASK_EN
    logic [KW-1:0]    wr_mask;
`endif
    logic             inv_en;
    logic [AW-1:0]    inv_addr;
    logic             flush;
    logic             busy;
    logic             srch_en;
    logic [KW-1:0]    srch_key;
    logic             match_valid;
    logic [DEPTH-1:0] match_vec;

    int checks = 0;
    int errors = 0;

    cam_store dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_key      (wr_key),
`ifdef CAM_STORE_MASK_EN
        .wr_mask     (wr_mask),
`endif
        .inv_en      (inv_en),
        .inv_addr    (inv_addr),
        .flush       (flush),
        .busy        (busy),
        .srch_en     (srch_en),
        .srch_key    (srch_key),
        .match_valid (match_valid),
        .match_vec   (match_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [DEPTH-1:0] bit_at(input int idx);
        logic [DEPTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_key   = '0;
`ifdef CAM_STORE_MASK_EN
        wr_mask  = '0;
`endif
        inv_en   = 1'b0;
        inv_addr = '0;
        flush    = 1'b0;
        srch_en  = 1'b0;
        srch_key = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [KW-1:0] key);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_key  = key;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_search(input logic [KW-1:0] key, output logic v,
                             output logic [DEPTH-1:0] vec);
        srch_en  = 1'b1;
        srch_key = key;
        tick();
        v        = match_valid;
        vec      = match_vec;
        srch_en  = 1'b0;
    endtask

    task automatic test_reset();
        logic             v;
        logic [DEPTH-1:0] vec;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || match_valid !== 1'b0 || match_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b mv=%b vec=%h expected 0 0 0", busy, match_valid, match_vec);
        end
        rst_n = 1'b1;
        tick();
        do_search(16'h0000, v, vec);
        checks++;
        if (v !== 1'b1 || vec !== '0) begin
            errors++;
            $display("FAIL reset_empty_search: mv=%b vec=%h expected 1 0", v, vec);
        end
    endtask

    task automatic test_basic();
        logic             v;
        logic [DEPTH-1:0] vec;
        do_write(8'd5, 16'h1234);
        do_search(16'h1234, v, vec);
        checks++;
        if (v !== 1'b1 || vec !== bit_at(5)) begin
            errors++;
            $display("FAIL basic_match: mv=%b vec=%h expected 1 %h", v, vec, bit_at(5));
        end
        do_search(16'h1235, v, vec);
        checks++;
        if (v !== 1'b1 || vec !== '0) begin
            errors++;
            $display("FAIL basic_miss: mv=%b vec=%h expected 1 0", v, vec);
        end
        tick();
        checks++;
        if (match_valid !== 1'b0 || match_vec !== '0) begin
            errors++;
            $display("FAIL no_search: mv=%b vec=%h expected 0 0", match_valid, match_vec);
        end
    endtask

    task automatic test_multi_inv();
        logic             v;
        logic [DEPTH-1:0] vec;
        do_write(8'd3, 16'hBEEF);
        do_write(8'd9, 16'hBEEF);
        do_search(16'hBEEF, v, vec);
        checks++;
        if (vec !== (bit_at(3) | bit_at(9))) begin
            errors++;
            $display("FAIL multi_match: vec=%h expected %h", vec, bit_at(3) | bit_at(9));
        end
        inv_en   = 1'b1;
        inv_addr = 8'd3;
        tick();
        inv_en   = 1'b0;
        do_search(16'hBEEF, v, vec);
        checks++;
        if (vec !== bit_at(9)) begin
            errors++;
            $display("FAIL invalidate: vec=%h expected %h", vec, bit_at(9));
        end
    endtask

    task automatic test_same_cycle();
        logic             v;
        logic [DEPTH-1:0] vec;
        wr_en    = 1'b1;
        wr_addr  = 8'd12;
        wr_key   = 16'h0001;
        srch_en  = 1'b1;
        srch_key = 16'h0001;
        tick();
        wr_en    = 1'b0;
        srch_en  = 1'b0;
        checks++;
        if (match_valid !== 1'b1 || match_vec !== '0) begin
            errors++;
            $display("FAIL same_cycle_pre_write: mv=%b vec=%h expected 1 0", match_valid, match_vec);
        end
        do_search(16'h0001, v, vec);
        checks++;
        if (vec !== bit_at(12)) begin
            errors++;
            $display("FAIL same_cycle_next: vec=%h expected %h", vec, bit_at(12));
        end
    endtask

    task automatic test_wr_inv();
        logic             v;
        logic [DEPTH-1:0] vec;
        wr_en    = 1'b1;
        wr_addr  = 8'd7;
        wr_key   = 16'h7777;
        inv_en   = 1'b1;
        inv_addr = 8'd7;
        tick();
        wr_en    = 1'b0;
        inv_en   = 1'b0;
        do_search(16'h7777, v, vec);
        checks++;
        if (v !== 1'b1 || vec !== '0) begin
            errors++;
            $display("FAIL wr_inv_same_addr: mv=%b vec=%h expected 1 0", v, vec);
        end
        wr_en    = 1'b1;
        wr_addr  = 8'd20;
        wr_key   = 16'h2020;
        inv_en   = 1'b1;
        inv_addr = 8'd9;
        tick();
        wr_en    = 1'b0;
        inv_en   = 1'b0;
        do_search(16'hBEEF, v, vec);
        checks++;
        if (vec !== '0) begin
            errors++;
            $display("FAIL wr_inv_diff_inv: vec=%h expected 0", vec);
        end
        do_search(16'h2020, v, vec);
        checks++;
        if (vec !== bit_at(20)) begin
            errors++;
            $display("FAIL wr_inv_diff_wr: vec=%h expected %h", vec, bit_at(20));
        end
        do_write(8'd20, 16'h2021);
        do_search(16'h2021, v, vec);
        checks++;
        if (vec !== bit_at(20)) begin
            errors++;
            $display("FAIL overwrite_new: vec=%h expected %h", vec, bit_at(20));
        end
        do_search(16'h2020, v, vec);
        checks++;
        if (vec !== '0) begin
            errors++;
            $display("FAIL overwrite_old: vec=%h expected 0", vec);
        end
    endtask

    task automatic test_back_to_back();
        srch_en  = 1'b1;
        srch_key = 16'h1234;
        tick();
        checks++;
        if (match_valid !== 1'b1 || match_vec !== bit_at(5)) begin
            errors++;
            $display("FAIL b2b_first: mv=%b vec=%h expected 1 %h", match_valid, match_vec, bit_at(5));
        end
        srch_key = 16'h0001;
        tick();
        checks++;
        if (match_valid !== 1'b1 || match_vec !== bit_at(12)) begin
            errors++;
            $display("FAIL b2b_second: mv=%b vec=%h expected 1 %h", match_valid, match_vec, bit_at(12));
        end
        srch_key = 16'h2021;
        tick();
        srch_en  = 1'b0;
        checks++;
        if (match_valid !== 1'b1 || match_vec !== bit_at(20)) begin
            errors++;
            $display("FAIL b2b_third: mv=%b vec=%h expected 1 %h", match_valid, match_vec, bit_at(20));
        end
    endtask

    task automatic test_mask();
        logic             v;
        logic [DEPTH-1:0] vec;
        wr_en   = 1'b1;
        wr_addr = 8'd70;
        wr_key  = 16'h12F0;
`ifdef CAM_STORE_MASK_EN
        wr_mask = 16'h000F;
`endif
        tick();
        wr_en   = 1'b0;
`ifdef CAM_STORE_MASK_EN
        wr_mask = '0;
`endif
        do_search(16'h12F7, v, vec);
        checks++;
`ifdef CAM_STORE_MASK_EN
        if (vec !== bit_at(70)) begin
            errors++;
            $display("FAIL mask_dont_care: vec=%h expected %h", vec, bit_at(70));
        end
`else
        if (vec !== '0) begin
            errors++;
            $display("FAIL exact_low_bits: vec=%h expected 0", vec);
        end
`endif
        do_search(16'h13F0, v, vec);
        checks++;
        if (vec !== '0) begin
            errors++;
            $display("FAIL mask_care_bit: vec=%h expected 0", vec);
        end
        do_search(16'h12F0, v, vec);
        checks++;
        if (vec !== bit_at(70)) begin
            errors++;
            $display("FAIL mask_exact: vec=%h expected %h", vec, bit_at(70));
        end
    endtask

    task automatic test_flush();
        logic             v;
        logic [DEPTH-1:0] vec;
        logic [KW-1:0]    keys [5];
        int               busy_cycles;
        int               bad_cycles;
        keys = '{16'h1234, 16'h0001, 16'h2021, 16'h12F0, 16'hAAAA};
        flush    = 1'b1;
        srch_en  = 1'b1;
        srch_key = 16'h1234;
        tick();
        checks++;
        if (busy !== 1'b1 || match_valid !== 1'b1 || match_vec !== bit_at(5)) begin
            errors++;
            $display("FAIL flush_start: busy=%b mv=%b vec=%h expected 1 1 %h", busy, match_valid, match_vec, bit_at(5));
        end
        wr_en    = 1'b1;
        wr_addr  = 8'd40;
        wr_key   = 16'hAAAA;
        inv_en   = 1'b1;
        inv_addr = 8'd5;
        busy_cycles = 0;
        bad_cycles  = 0;
        while (busy === 1'b1 && busy_cycles < DEPTH + 8) begin
            busy_cycles++;
            if (busy_cycles > 1 && (match_valid !== 1'b0 || match_vec !== bit_at(5)))
                bad_cycles++;
            tick();
        end
        idle_inputs();
        wr_en   = 1'b1;
        wr_addr = 8'd50;
        wr_key  = 16'h5555;
        checks++;
        if (busy_cycles !== DEPTH) begin
            errors++;
            $display("FAIL flush_busy_len: got %0d cycles expected %0d", busy_cycles, DEPTH);
        end
        checks++;
        if (bad_cycles !== 0 || match_valid !== 1'b0 || match_vec !== bit_at(5)) begin
            errors++;
            $display("FAIL flush_hold: bad=%0d mv=%b vec=%h expected 0 0 %h", bad_cycles, match_valid, match_vec, bit_at(5));
        end
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            do_search(keys[k], v, vec);
            checks++;
            if (v !== 1'b1 || vec !== '0) begin
                errors++;
                $display("FAIL flush_cleared key=%h: mv=%b vec=%h expected 1 0", keys[k], v, vec);
            end
        end
        do_search(16'h5555, v, vec);
        checks++;
        if (vec !== bit_at(50)) begin
            errors++;
            $display("FAIL flush_first_op: vec=%h expected %h", vec, bit_at(50));
        end
    endtask

    task automatic test_flush_reset();
        logic             v;
        logic [DEPTH-1:0] vec;
        do_write(8'd60, 16'h6060);
        flush    = 1'b1;
        srch_en  = 1'b1;
        srch_key = 16'h6060;
        tick();
        idle_inputs();
        checks++;
        if (busy !== 1'b1 || match_vec !== bit_at(60)) begin
            errors++;
            $display("FAIL flush2_start: busy=%b vec=%h expected 1 %h", busy, match_vec, bit_at(60));
        end
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || match_valid !== 1'b0 || match_vec !== '0) begin
            errors++;
            $display("FAIL flush_abort: busy=%b mv=%b vec=%h expected 0 0 0", busy, match_valid, match_vec);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_abort_idle: busy=%b expected 0", busy);
        end
        do_search(16'h6060, v, vec);
        checks++;
        if (v !== 1'b1 || vec !== '0) begin
            errors++;
            $display("FAIL flush_abort_cleared: mv=%b vec=%h expected 1 0", v, vec);
        end
        do_write(8'd61, 16'h6161);
        do_search(16'h6161, v, vec);
        checks++;
        if (vec !== bit_at(61)) begin
            errors++;
            $display("FAIL post_abort_write: vec=%h expected %h", vec, bit_at(61));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_multi_inv();
        test_same_cycle();
        test_wr_inv();
        test_back_to_back();
        test_mask();
        test_flush();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cam_store

// File: doc/cam_store.md
# cam_store

Key-storage and compare stage of the CAM: holds DEPTH entries of KEY_WIDTH-bit keys with valid bits, compares a search key against all entries in parallel, and outputs a registered one-hot-or-multi-hot match vector. match_vec drives the data input of the downstream priority-encoder stage, which turns it into hit/address. Write, invalidate and a sequenced flush are also provided.

## Interface
- ADDR_WIDTH, 8, entry index width
- DEPTH, 1 << ADDR_WIDTH, number of entries
- KEY_WIDTH, 16, key width in bits
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write entry wr_addr with wr_key, set valid
- wr_addr  in  ADDR_WIDTH  write index
- wr_key  in  KEY_WIDTH  key to store
- wr_mask  in  KEY_WIDTH  per-bit don't-care (1 = ignore); present only with CAM_STORE_MASK_EN
- inv_en  in  1  clear valid of entry inv_addr
- inv_addr  in  ADDR_WIDTH  invalidate index
- flush  in  1  start clearing all valid bits
- busy  out  1  flush in progress
- srch_en  in  1  search request
- srch_key  in  KEY_WIDTH  search key
- match_valid  out  1  match_vec holds a search result this cycle
- match_vec  out  DEPTH  bit i = 1 when entry i valid and matches

## Operation
- Reset: all valid bits 0, state IDLE, flush counter 0, busy 0, match_valid 0, match_vec 0. Key/mask storage not reset.
- FSM states IDLE, FLUSH.
- IDLE: wr_en/inv_en/srch_en accepted. flush=1 -> FLUSH, counter 0, busy 1 from next cycle.
- FLUSH: each cycle clears valid[counter], counter +1; after clearing entry DEPTH-1 -> IDLE, busy 0. Exactly DEPTH cycles in FLUSH. One valid write per cycle bounds write-enable fanout.
- In FLUSH: wr_en, inv_en, srch_en, flush ignored; match_valid 0, match_vec holds last value.
- Match rule: entry i matches when valid[i] and (key[i] ^ srch_key) has no set bits outside mask[i] (mask all-0 when feature off).
- wr_en and inv_en same cycle, same address: invalidate wins, key still written, valid 0. Different addresses: both take effect.
- Writing an already-valid entry overwrites key, valid stays 1.
- Multiple matches permitted; resolution is downstream.
- srch_en=0: match_valid 0, match_vec 0.

## Timing
- Search latency 1: srch_en at cycle N -> match_valid=1, match_vec at cycle N+1, both registered.
- Write/invalidate at cycle N affects searches issued at N+1 onward; search in cycle N sees pre-write contents.
- Back-to-back searches every cycle supported; no stall outside FLUSH.
- flush at cycle N: busy=1 cycles N+1..N+DEPTH, 0 at N+DEPTH+1; first new op accepted at N+DEPTH+1.
- rst_n low mid-flush: aborts sweep, IDLE, all valid 0 next cycle.

## Configuration
- CAM_STORE_MASK_EN defined: per-entry mask stored on write via wr_mask; ternary compare as above.
- Undefined: wr_mask port and mask storage absent; exact-match compare only.

## Structure
- Package cam_pkg: state enum (IDLE, FLUSH), default ADDR_WIDTH/KEY_WIDTH constants.
- Sub-module cam_entry: one key (+mask) register, valid flop, and comparator; generated DEPTH times, outputs raw match bit. Top holds FSM, counter, output registers.

## Test plan
- Reset, write entry 5 key 0x1234, search 0x1234 next cycle -> match_valid=1, match_vec=1<<5 one cycle later.
- Write entries 3 and 9 key 0xBEEF, search 0xBEEF -> bits 3 and 9 set; inv_en addr 3, search -> only bit 9.
- Write and search same entry same cycle key 0x0001 -> result excludes entry; repeat search next cycle -> bit set.
- wr_en and inv_en both addr 7 -> search of written key returns no match for entry 7.
- Fill several entries, flush -> busy high exactly DEPTH cycles, searches/writes during sweep ignored, afterward any search -> match_vec=0; rst_n low at sweep cycle 10 -> busy 0, IDLE next cycle.
- With CAM_STORE_MASK_EN: write key 0x12F0 mask 0x000F, search 0x12F7 -> match; search 0x13F0 -> no match.
